// File: rtl/bpred_resolve_unit.sv
// Branch resolve unit: in-order prediction queue checked against execute results.
// Emits predictor updates and fetch redirects, then drains the pipe after a miss.
module bpred_resolve_unit #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int DRAIN = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  input  logic        f_pred_dir,
  input  logic [31:0] f_pred_target,
  input  logic [1:0]  f_ctr,
  input  logic [3:0]  f_ras_index,
  output logic        f_full,
  input  logic        e_valid,
  input  logic        e_is_branch,
  input  logic        e_taken,
  input  logic [31:0] e_target,
  input  logic        stall,
  output logic        execute_bpredictor_update,
  output logic [31:0] execute_bpredictor_PC4,
  output logic [31:0] execute_bpredictor_target,
  output logic        execute_bpredictor_dir,
  output logic        execute_bpredictor_miss,
  output logic        execute_bpredictor_recover_ras,
  output logic [3:0]  execute_bpredictor_ras_index,
  output logic [13:0] execute_bpredictor_meta,
  output logic        fetch_redirect,
  output logic [31:0] fetch_redirect_PC
);

  localparam int CNT_W = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);
  localparam int QC_W  = PTR_W + 1;

  typedef enum logic {
    S_RUN,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_run;

  logic [CNT_W-1:0] r_drain;

  logic [31:0] r_q_pc  [DEPTH];
  logic        r_q_dir [DEPTH];
  logic [31:0] r_q_tgt [DEPTH];
  logic [1:0]  r_q_ctr [DEPTH];
  logic [3:0]  r_q_ras [DEPTH];

  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [QC_W-1:0]  r_count;

  logic        w_push;
  logic        w_pop;
  logic        w_flush;
  logic [31:0] w_hd_pc;
  logic        w_hd_dir;
  logic [31:0] w_hd_tgt;
  logic [1:0]  w_hd_ctr;
  logic [3:0]  w_hd_ras;
  logic [31:0] w_pc4;
  logic [31:0] w_next_pc;
  logic        w_miss;
  logic [1:0]  w_new_ctr;

  logic        r_update;
  logic [31:0] r_pc4;
  logic [31:0] r_target;
  logic        r_dir;
  logic        r_miss;
  logic        r_recover;
  logic [3:0]  r_ras;
  logic [13:0] r_meta;
  logic        r_redirect;
  logic [31:0] r_redirect_pc;

  assign f_full  = (r_count == QC_W'(DEPTH));
  assign w_push  = f_valid & ~f_full & w_run;
  assign w_pop   = e_valid & (r_count != '0) & ~stall & w_run;
  assign w_flush = w_pop & w_miss;

  assign w_hd_pc  = r_q_pc[r_rd];
  assign w_hd_dir = r_q_dir[r_rd];
  assign w_hd_tgt = r_q_tgt[r_rd];
  assign w_hd_ctr = r_q_ctr[r_rd];
  assign w_hd_ras = r_q_ras[r_rd];

  assign w_pc4     = w_hd_pc + 32'd4;
  assign w_next_pc = (e_is_branch & e_taken) ? e_target : w_pc4;

  // Compare the queued prediction with the resolved outcome
  always_comb begin
    w_miss = w_hd_dir;
    if (e_is_branch) begin
      w_miss = (w_hd_dir != e_taken) |
               (e_taken & (w_hd_tgt != e_target));
    end
  end

  // Saturating bimodal counter step toward the actual direction
  always_comb begin
    w_new_ctr = w_hd_ctr;
    if (e_taken) begin
      if (w_hd_ctr != 2'b11) w_new_ctr = w_hd_ctr + 2'd1;
    end else begin
      if (w_hd_ctr != 2'b00) w_new_ctr = w_hd_ctr - 2'd1;
    end
  end

  // Prediction record storage; stale slots are never read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr]  <= f_pc;
      r_q_dir[r_wr] <= f_pred_dir;
      r_q_tgt[r_wr] <= f_pred_target;
      r_q_ctr[r_wr] <= f_ctr;
      r_q_ras[r_wr] <= f_ras_index;
    end
  end

  // Queue pointers and occupancy; a miss flushes everything in flight
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: drain for DRAIN cycles after a miss
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN:   if (w_flush) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain == CNT_W'(1)) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_run = 1'b0;
    unique case (r_state)
      S_RUN:   w_run = 1'b1;
      S_DRAIN: w_run = 1'b0;
      default: w_run = 1'b0;
    endcase
  end

  // Drain counter keeps counting through stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drain <= '0;
    end else if (w_flush) begin
      r_drain <= CNT_W'(DRAIN);
    end else if (r_state == S_DRAIN) begin
      r_drain <= r_drain - 1'b1;
    end
  end

  // Registered update/redirect bundle; strobes only on pop cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_update      <= 1'b0;
      r_pc4         <= '0;
      r_target      <= '0;
      r_dir         <= 1'b0;
      r_miss        <= 1'b0;
      r_recover     <= 1'b0;
      r_ras         <= '0;
      r_meta        <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_update   <= w_pop & e_is_branch;
      r_redirect <= w_flush;
      r_recover  <= w_flush;
      if (w_pop) begin
        r_pc4         <= w_pc4;
        r_target      <= e_target;
        r_dir         <= e_taken;
        r_miss        <= w_miss;
        r_ras         <= w_hd_ras;
        r_meta        <= {w_new_ctr, w_hd_pc[13:2]};
        r_redirect_pc <= w_next_pc;
      end
    end
  end

  assign execute_bpredictor_update      = r_update;
  assign execute_bpredictor_PC4         = r_pc4;
  assign execute_bpredictor_target      = r_target;
  assign execute_bpredictor_dir         = r_dir;
  assign execute_bpredictor_miss        = r_miss;
  assign execute_bpredictor_recover_ras = r_recover;
  assign execute_bpredictor_ras_index   = r_ras;
  assign execute_bpredictor_meta        = r_meta;
  assign fetch_redirect                 = r_redirect;
  assign fetch_redirect_PC              = r_redirect_pc;

endmodule

// File: tb/tb_bpred_resolve_unit.sv
// Bench for bpred_resolve_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_bpred_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        f_pred_dir;
  logic [31:0] f_pred_target;
  logic [1:0]  f_ctr;
  logic [3:0]  f_ras_index;
  logic        f_full;
  logic        e_valid;
  logic        e_is_branch;
  logic        e_taken;
  logic [31:0] e_target;
  logic        stall;
  logic        upd;
  logic [31:0] pc4;
  logic [31:0] tgt;
  logic        dir;
  logic        miss;
  logic        rras;
  logic [3:0]  ras;
  logic [13:0] meta;
  logic        redir;
  logic [31:0] redir_pc;

  always #5 clk = ~clk;

  bpred_resolve_unit dut (
    .clk                            (clk),
    .reset                          (reset),
    .f_valid                        (f_valid),
    .f_pc                           (f_pc),
    .f_pred_dir                     (f_pred_dir),
    .f_pred_target                  (f_pred_target),
    .f_ctr                          (f_ctr),
    .f_ras_index                    (f_ras_index),
    .f_full                         (f_full),
    .e_valid                        (e_valid),
    .e_is_branch                    (e_is_branch),
    .e_taken                        (e_taken),
    .e_target                       (e_target),
    .stall                          (stall),
    .execute_bpredictor_update      (upd),
    .execute_bpredictor_PC4         (pc4),
    .execute_bpredictor_target      (tgt),
    .execute_bpredictor_dir         (dir),
    .execute_bpredictor_miss        (miss),
    .execute_bpredictor_recover_ras (rras),
    .execute_bpredictor_ras_index   (ras),
    .execute_bpredictor_meta        (meta),
    .fetch_redirect                 (redir),
    .fetch_redirect_PC              (redir_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic        dir;
    logic [31:0] tgt;
    logic [1:0]  ctr;
    logic [3:0]  ras;
  } rec_t;

  rec_t mq[$];
  int   m_drain;
  int   n_chk = 0;
  int   n_pass = 0;

  logic        x_upd, x_dir, x_miss, x_rras, x_redir;
  logic [31:0] x_pc4, x_tgt, x_redir_pc;
  logic [3:0]  x_ras;
  logic [13:0] x_meta;

  logic [118:0] dut_all;
  logic [118:0] exp_all;
  assign dut_all = {upd, pc4, tgt, dir, miss, rras, ras, meta,
                    redir, redir_pc};
  assign exp_all = {x_upd, x_pc4, x_tgt, x_dir, x_miss, x_rras, x_ras,
                    x_meta, x_redir, x_redir_pc};

  task automatic idle();
    f_valid = 0; f_pc = 0; f_pred_dir = 0; f_pred_target = 0;
    f_ctr = 0; f_ras_index = 0;
    e_valid = 0; e_is_branch = 0; e_taken = 0; e_target = 0;
    stall = 0;
  endtask

  task automatic push_in(input logic [31:0] pc, input logic d,
                         input logic [31:0] t, input logic [1:0] c,
                         input logic [3:0] r);
    f_valid = 1; f_pc = pc; f_pred_dir = d; f_pred_target = t;
    f_ctr = c; f_ras_index = r;
  endtask

  task automatic res_in(input logic b, input logic tk,
                        input logic [31:0] t);
    e_valid = 1; e_is_branch = b; e_taken = tk; e_target = t;
  endtask

  // Advance the model by one clock, then the DUT; returns 1ns after the edge.
  task automatic tick();
    bit run, push, pop, mp;
    rec_t r;
    int nc;
    x_upd = 0; x_redir = 0; x_rras = 0;
    if (reset) begin
      mq.delete(); m_drain = 0;
      x_pc4 = 0; x_tgt = 0; x_dir = 0; x_miss = 0;
      x_ras = 0; x_meta = 0; x_redir_pc = 0;
    end else begin
      run  = (m_drain == 0);
      push = f_valid && (mq.size() < 8) && run;
      pop  = e_valid && (mq.size() != 0) && !stall && run;
      mp   = 0;
      if (pop) begin
        r = mq[0];
        if (e_is_branch)
          mp = (r.dir != e_taken) || (e_taken && r.tgt != e_target);
        else
          mp = r.dir;
        nc = e_taken ? int'(r.ctr) + 1 : int'(r.ctr) - 1;
        if (nc > 3) nc = 3;
        if (nc < 0) nc = 0;
        x_upd = e_is_branch;
        x_pc4 = r.pc + 32'd4;
        x_tgt = e_target;
        x_dir = e_taken;
        x_miss = mp;
        x_ras = r.ras;
        x_meta = {nc[1:0], r.pc[13:2]};
        x_redir = mp;
        x_rras = mp;
        x_redir_pc = (e_is_branch && e_taken) ? e_target : r.pc + 32'd4;
      end
      if (!run) begin
        m_drain--;
      end else if (pop && mp) begin
        mq.delete();
        m_drain = 2;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back('{f_pc, f_pred_dir, f_pred_target,
                                 f_ctr, f_ras_index});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; idle(); tick(); reset = 0;
    n_chk++;
    if (dut_all !== 119'd0)
      $display("FAIL reset_outputs got %h want 0", dut_all);
    else n_pass++;
    n_chk++;
    if (f_full !== 1'b0) $display("FAIL reset_full got %b want 0", f_full);
    else n_pass++;
  endtask

  task automatic test_correct_taken();
    idle(); push_in(32'h100, 1, 32'h140, 2'd2, 4'd5); tick();
    idle(); res_in(1, 1, 32'h140); tick();
    n_chk++;
    if (upd !== 1'b1 || miss !== 1'b0 || redir !== 1'b0 || rras !== 1'b0)
      $display("FAIL hit_flags got u%b m%b r%b rr%b want u1 m0 r0 rr0",
               upd, miss, redir, rras);
    else n_pass++;
    n_chk++;
    if (meta !== 14'h3040) $display("FAIL hit_meta got %h want 3040", meta);
    else n_pass++;
    n_chk++;
    if (pc4 !== 32'h104 || tgt !== 32'h140 || dir !== 1'b1)
      $display("FAIL hit_data got %h %h %b want 104 140 1", pc4, tgt, dir);
    else n_pass++;
    idle(); tick();
    n_chk++;
    if (upd !== 1'b0 || meta !== 14'h3040)
      $display("FAIL hit_hold got u%b meta %h want u0 3040", upd, meta);
    else n_pass++;
  endtask

  task automatic test_mispredict();
    idle(); push_in(32'h80, 0, 32'h0, 2'd1, 4'd3); tick();
    idle(); res_in(1, 1, 32'h200); push_in(32'h90, 0, 0, 0, 0); tick();
    n_chk++;
    if (miss !== 1'b1 || redir !== 1'b1 || rras !== 1'b1 || upd !== 1'b1)
      $display("FAIL miss_flags got m%b r%b rr%b u%b want 1111",
               miss, redir, rras, upd);
    else n_pass++;
    n_chk++;
    if (redir_pc !== 32'h200 || ras !== 4'd3 || meta !== 14'h2020)
      $display("FAIL miss_data got %h %h %h want 200 3 2020",
               redir_pc, ras, meta);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      idle(); push_in(32'h300 + 32'(i * 4), 1, 32'h0, 0, 0);
      res_in(1, 0, 0); tick();
      n_chk++;
      if (upd !== 1'b0 || redir !== 1'b0 || rras !== 1'b0 || f_full !== 1'b0)
        $display("FAIL drain_quiet cyc %0d got u%b r%b rr%b f%b want 0000",
                 i, upd, redir, rras, f_full);
      else n_pass++;
    end
    idle(); res_in(1, 0, 0); tick();
    n_chk++;
    if (upd !== 1'b0) $display("FAIL drain_dropped got u%b want 0", upd);
    else n_pass++;
    idle(); push_in(32'h600, 0, 0, 1, 1); tick();
    idle(); res_in(1, 0, 0); tick();
    n_chk++;
    if (upd !== 1'b1 || pc4 !== 32'h604 || miss !== 1'b0)
      $display("FAIL drain_exit got u%b pc4 %h m%b want 1 604 0",
               upd, pc4, miss);
    else n_pass++;
  endtask

  task automatic test_saturation();
    idle(); push_in(32'h400, 1, 32'h10, 2'd3, 0); tick();
    idle(); res_in(1, 1, 32'h10); tick();
    n_chk++;
    if (meta !== 14'h3100 || miss !== 1'b0)
      $display("FAIL sat_hi got meta %h m%b want 3100 0", meta, miss);
    else n_pass++;
    idle(); push_in(32'h404, 0, 32'h0, 2'd0, 0); tick();
    idle(); res_in(1, 0, 32'h0); tick();
    n_chk++;
    if (meta !== 14'h0101 || miss !== 1'b0 || upd !== 1'b1)
      $display("FAIL sat_lo got meta %h m%b u%b want 0101 0 1",
               meta, miss, upd);
    else n_pass++;
    idle(); push_in(32'h500, 0, 32'h0, 2'd1, 0); tick();
    idle(); res_in(0, 0, 32'h0); tick();
    n_chk++;
    if (upd !== 1'b0 || miss !== 1'b0 || redir !== 1'b0 || pc4 !== 32'h504)
      $display("FAIL nonbranch got u%b m%b r%b pc4 %h want 0 0 0 504",
               upd, miss, redir, pc4);
    else n_pass++;
  endtask

  task automatic test_full();
    logic [31:0] want;
    for (int i = 0; i < 8; i++) begin
      idle(); push_in(32'h1000 + 32'(i * 4), 0, 0, 2'd1, 4'(i)); tick();
      n_chk++;
      if (f_full !== (i == 7))
        $display("FAIL full_fill %0d got %b want %b", i, f_full, i == 7);
      else n_pass++;
    end
    idle(); push_in(32'h2000, 0, 0, 0, 0); tick();
    idle(); push_in(32'h3000, 0, 0, 0, 0); res_in(1, 0, 0); tick();
    n_chk++;
    if (f_full !== 1'b0 || pc4 !== 32'h1004)
      $display("FAIL full_pop got f%b pc4 %h want 0 1004", f_full, pc4);
    else n_pass++;
    for (int i = 1; i < 4; i++) begin
      idle(); res_in(1, 0, 0); tick();
    end
    idle(); push_in(32'h1100, 0, 0, 0, 0); res_in(1, 0, 0); tick();
    n_chk++;
    if (pc4 !== 32'h1014 || upd !== 1'b1)
      $display("FAIL full_pushpop got pc4 %h u%b want 1014 1", pc4, upd);
    else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      idle(); push_in(32'h1100 + 32'(i * 4), 0, 0, 0, 0); tick();
      n_chk++;
      if (f_full !== (i == 4))
        $display("FAIL full_refill %0d got %b want %b", i, f_full, i == 4);
      else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      idle(); res_in(1, 0, 0); tick();
      want = (i < 3) ? 32'h1018 + 32'(i * 4) : 32'h1104 + 32'((i - 3) * 4);
      n_chk++;
      if (pc4 !== want || upd !== 1'b1)
        $display("FAIL full_drain %0d got pc4 %h u%b want %h 1",
                 i, pc4, upd, want);
      else n_pass++;
    end
    idle(); res_in(1, 0, 0); tick();
    n_chk++;
    if (upd !== 1'b0) $display("FAIL empty_pop got u%b want 0", upd);
    else n_pass++;
  endtask

  task automatic test_stall();
    idle(); push_in(32'h700, 0, 0, 1, 2); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); stall = 1; res_in(1, 0, 0);
      if (i == 0) push_in(32'h704, 0, 0, 1, 2);
      tick();
      n_chk++;
      if (upd !== 1'b0 || redir !== 1'b0 || dut_all !== exp_all)
        $display("FAIL stall_hold %0d got %h want %h", i, dut_all, exp_all);
      else n_pass++;
    end
    idle(); res_in(1, 0, 0); tick();
    n_chk++;
    if (upd !== 1'b1 || pc4 !== 32'h704)
      $display("FAIL stall_release got u%b pc4 %h want 1 704", upd, pc4);
    else n_pass++;
    idle(); res_in(1, 0, 0); tick();
    n_chk++;
    if (upd !== 1'b1 || pc4 !== 32'h708)
      $display("FAIL stall_second got u%b pc4 %h want 1 708", upd, pc4);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(0, 2) != 0)
        push_in({$urandom_range(0, 4095), 2'b00}, 1'($urandom_range(0, 1)),
                {$urandom_range(0, 15), 4'h0}, 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) != 0) begin
        res_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               {$urandom_range(0, 15), 4'h0});
        if (mq.size() != 0 && $urandom_range(0, 3) != 0) begin
          e_taken  = mq[0].dir;
          e_target = mq[0].tgt;
        end
      end
      stall = ($urandom_range(0, 7) == 0);
      tick();
      n_chk++;
      if (dut_all !== exp_all || f_full !== (mq.size() == 8))
        $display("FAIL random cyc %0d got %h f%b want %h f%b", c,
                 dut_all, f_full, exp_all, mq.size() == 8);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    idle();
    for (int i = 0; i < 5; i++) begin
      push_in(32'h800 + 32'(i * 4), 1, 32'h900, 3, 7); tick();
    end
    idle(); res_in(1, 1, 32'h900); tick();
    reset = 1; idle(); tick(); reset = 0;
    n_chk++;
    if (dut_all !== 119'd0 || f_full !== 1'b0)
      $display("FAIL rst_mid got %h f%b want 0 0", dut_all, f_full);
    else n_pass++;
    idle(); res_in(1, 0, 0); tick();
    n_chk++;
    if (upd !== 1'b0) $display("FAIL rst_empty got u%b want 0", upd);
    else n_pass++;
    idle(); push_in(32'h40, 0, 0, 0, 9); tick();
    idle(); res_in(1, 1, 32'h44); tick();
    reset = 1; idle(); tick(); reset = 0;
    n_chk++;
    if (dut_all !== 119'd0 || f_full !== 1'b0)
      $display("FAIL rst_drain got %h f%b want 0 0", dut_all, f_full);
    else n_pass++;
    idle(); push_in(32'h50, 0, 0, 1, 1); tick();
    idle(); res_in(1, 0, 0); tick();
    n_chk++;
    if (upd !== 1'b1 || pc4 !== 32'h54)
      $display("FAIL rst_run got u%b pc4 %h want 1 54", upd, pc4);
    else n_pass++;
  endtask

  initial begin
    reset = 1;
    idle();
    m_drain = 0;
    test_reset();
    test_correct_taken();
    test_mispredict();
    test_saturation();
    test_full();
    test_stall();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
